// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: shared widths and entry type for the CPU output-port path.
package cpu_io_pkg;
  localparam int PORT_W    = 2;
  localparam int DATA_W    = 16;
  localparam int NUM_PORTS = 4;
  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [DATA_W-1:0] data;
  } out_entry_t;
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO; a push into a full FIFO succeeds only alongside a pop.
module fifo_sync #(
  parameter  int DEPTH = 4,
  parameter  int W     = 18,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;
  assign count = count_q;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/out_port_unit.sv
// out_port_unit: queues CPU output writes and drains them over valid/ready into o0..o3.
// Define CPUOUT_OVF_FLAG_EN to expose the sticky ovf flag and saturating drop_cnt.
module out_port_unit
  import cpu_io_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 16,
  localparam int CW     = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_out,
  input  logic [1:0]        port_sel,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_port,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] o0,
  output logic [DATA_W-1:0] o1,
  output logic [DATA_W-1:0] o2,
  output logic [DATA_W-1:0] o3
`ifdef CPUOUT_OVF_FLAG_EN
  ,
  output logic              ovf,
  output logic [7:0]        drop_cnt
`endif
);
  logic [PORT_W+DATA_W-1:0] head;
  logic [DATA_W-1:0]        o_q [NUM_PORTS];
  logic [DATA_W-1:0]        o_d [NUM_PORTS];
  logic                     empty, pop;
  fifo_sync #(.DEPTH(DEPTH), .W(PORT_W+DATA_W)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (we_out),
    .pop  (out_ready),
    .din  ({port_sel, wdata}),
    .full (full),
    .empty(empty),
    .count(count),
    .head (head)
  );
  assign out_valid = !empty;
  assign out_port  = head[DATA_W +: PORT_W];
  assign out_data  = head[DATA_W-1:0];
  assign pop       = out_valid && out_ready;
  assign {o0, o1, o2, o3} = {o_q[0], o_q[1], o_q[2], o_q[3]};
  always_comb begin
    o_d = o_q;
    if (pop) o_d[out_port] = out_data;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) o_q <= '{default: '0};
    else        o_q <= o_d;
  end
`ifdef CPUOUT_OVF_FLAG_EN
  logic       ovf_q, ovf_d, drop;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;
  always_comb begin
    drop       = we_out && full && !pop;
    ovf_d      = ovf_q || drop;
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_out_port_unit.sv
// tb_out_port_unit: directed plan steps plus random traffic against a queue-based model.
module tb_out_port_unit;
  import cpu_io_pkg::*;
  localparam int DEPTH = 4;
  logic        clk = 1'b0, reset = 1'b0, we_out = 1'b0, out_ready = 1'b0;
  logic [1:0]  port_sel = '0, out_port;
  logic [15:0] wdata = '0, out_data, o0, o1, o2, o3;
  logic        full, out_valid;
  logic [2:0]  count;
`ifdef CPUOUT_OVF_FLAG_EN
  logic        ovf;
  logic [7:0]  drop_cnt;
`endif
  int          passed = 0, total = 0;
  out_entry_t  q[$];
  logic [15:0] om [4];
  int          m_drops = 0;

  out_port_unit #(.DEPTH(DEPTH), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .we_out(we_out), .port_sel(port_sel), .wdata(wdata),
    .full(full), .out_valid(out_valid), .out_ready(out_ready), .out_port(out_port),
    .out_data(out_data), .count(count), .o0(o0), .o1(o1), .o2(o2), .o3(o3)
`ifdef CPUOUT_OVF_FLAG_EN
    , .ovf(ovf), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    int n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".valid"}, 32'(out_valid), 32'(n != 0));
    chk({tag, ".port"}, 32'(out_port), n != 0 ? 32'(q[0].port) : 32'd0);
    chk({tag, ".data"}, 32'(out_data), n != 0 ? 32'(q[0].data) : 32'd0);
    chk({tag, ".o"}, {o3[7:0], o2[7:0], o1[7:0], o0[7:0]},
        {om[3][7:0], om[2][7:0], om[1][7:0], om[0][7:0]});
    chk({tag, ".ohi"}, {o3[15:8], o2[15:8], o1[15:8], o0[15:8]},
        {om[3][15:8], om[2][15:8], om[1][15:8], om[0][15:8]});
`ifdef CPUOUT_OVF_FLAG_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_drops != 0));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), m_drops > 255 ? 32'd255 : 32'(m_drops));
`endif
  endtask

  task automatic model_clear();
    q.delete();
    om = '{default: '0};
    m_drops = 0;
  endtask

  // Drive one cycle from a negedge, update the model at the posedge, check #1 later.
  task automatic step(input string tag, input logic we, input logic [1:0] p,
                      input logic [15:0] d, input logic rdy);
    bit do_pop, do_push;
    out_entry_t e;
    we_out = we; port_sel = p; wdata = d; out_ready = rdy;
    do_pop  = q.size() != 0 && rdy;
    do_push = we && (q.size() < DEPTH || do_pop);
    @(posedge clk);
    if (do_pop) begin
      e = q.pop_front();
      om[e.port] = e.data;
    end
    if (do_push) q.push_back('{port: p, data: d});
    else if (we) m_drops++;
    #1 chk_all(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    we_out = 0; out_ready = 0; reset = 0;
    model_clear();
    @(negedge clk);
    #1 chk_all("reset");
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    do_reset();
    // Single write, held with ready low, then consumed.
    step("w1", 1, 2, 16'hABCD, 0);
    step("hold", 0, 0, 0, 0);
    step("pop1", 0, 0, 0, 1);
    // Fill, drop a fifth write, drain in order.
    for (int i = 0; i < 4; i++) step("fill", 1, 2'(i), 16'(i + 1), 0);
    step("drop", 1, 0, 16'd5, 0);
    for (int i = 0; i < 4; i++) step("drain", 0, 0, 0, 1);
    step("empty_rdy", 0, 0, 0, 1);
    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step("fill2", 1, 2'(3 - i), 16'h100 + 16'(i), 0);
    step("full_pp", 1, 1, 16'hBEEF, 1);
    for (int i = 0; i < 4; i++) step("drain2", 0, 0, 0, 1);
    // Empty with push and ready: no pop that edge.
    step("empty_pp", 1, 3, 16'h5555, 1);
    step("drain3", 0, 0, 0, 1);
    // Asynchronous reset mid-cycle with two entries queued.
    step("pre_rst", 1, 1, 16'h1111, 0);
    step("pre_rst", 1, 3, 16'h3333, 0);
    #2 reset = 0;
    model_clear();
    #1 chk_all("async_rst");
    @(negedge clk);
    reset = 1;
`ifdef CPUOUT_OVF_FLAG_EN
    for (int i = 0; i < 4; i++) step("ovf_fill", 1, 2'(i), 16'h20 + 16'(i), 0);
    for (int i = 0; i < 3; i++) step("ovf_drop", 1, 0, 16'hDEAD, 0);
    for (int i = 0; i < 4; i++) step("ovf_drain", 0, 0, 0, 1);
`endif
    // Random traffic.
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom % 3) != 0, 2'($urandom), 16'($urandom), ($urandom % 2) == 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
